// File: rtl/cur_lcu_pkg.sv
// Shared definitions for the current-LCU buffer: FSM encoding, geometry
// derivation and the bank rotation helpers.

// Group g (0 = leftmost) of a 32-pixel beat; the MSB holds the leftmost pixel.
`define CUR_LCU_GRP(data, g, pw) data[(pw)*(32-8*(g))-1 -: (pw)*8]

package cur_lcu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Beats per line: one beat carries 32 pixels.
  function automatic int cur_bpr(input int lcu);
    return lcu / 32;
  endfunction

  // Luma lines plus half as many chroma lines (U|V packed per line).
  function automatic int cur_lines(input int lcu);
    return (lcu * 3) / 2;
  endfunction

  // Words held by each bank.
  function automatic int cur_depth(input int lcu);
    return cur_lines(lcu) * cur_bpr(lcu);
  endfunction

  // Bank holding group g of a line whose rotation is rot.
  function automatic logic [1:0] cur_bank_idx(input logic [1:0] g, input logic [1:0] rot);
    return g + rot;
  endfunction

  // Inverse of cur_bank_idx: which group bank b holds for rotation rot.
  function automatic logic [1:0] cur_grp_of_bank(input logic [1:0] b, input logic [1:0] rot);
    return b - rot;
  endfunction

endpackage

// File: rtl/cur_lcu_bank.sv
// Single-port bank RAM with synchronous read; a write in the same cycle as a
// read wins and leaves the read register untouched.

module cur_lcu_bank #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 48,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Storage array: no reset, contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: only updates on a read, so the last result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (re && !we) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cur_lcu_loader.sv
// Current-LCU buffer: loads one LCU from a valid/ready stream into four
// diagonally rotated banks and serves single-cycle row or column reads.

module cur_lcu_loader
  import cur_lcu_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int LCU_SIZE    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  output logic                      done_o,
  output logic                      busy_o,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [PIXEL_WIDTH*32-1:0] in_data_i,
  input  logic                      rd_en_i,
  input  logic                      rd_col_i,
  input  logic [6:0]                rd_line_i,
  input  logic                      rd_seg_i,
  input  logic [1:0]                rd_grp_i,
  output logic [PIXEL_WIDTH*32-1:0] rd_data_o,
  output logic                      rd_valid_o
);

  localparam int BPR   = cur_bpr(LCU_SIZE);
  localparam int LINES = cur_lines(LCU_SIZE);
  localparam int DEPTH = cur_depth(LCU_SIZE);
  localparam int AW    = $clog2(DEPTH);
  localparam int GW    = PIXEL_WIDTH * 8;
  localparam int DW    = PIXEL_WIDTH * 32;

  state_e      state_r;
  logic [6:0]  line_r;
  logic        seg_r;
  logic        busy_r;
  logic        done_r;
  logic        rd_valid_r;
  logic [1:0]  sel_r;

  logic          seg_last_s;
  logic          line_last_s;
  logic          beat_s;
  logic          rd_go_s;
  logic [AW-1:0] waddr_s;
  logic [GW-1:0] in_grp_s [4];
  logic [GW-1:0] bank_q_s [4];

  // Word address of (line, segment) inside every bank.
  function automatic logic [AW-1:0] line_addr(input logic [6:0] line, input logic seg);
    logic [8:0] a;
    a = ({2'b00, line} * 9'(BPR)) + {8'd0, seg};
    return AW'(a);
  endfunction

  // With one beat per line the segment counter never leaves 0.
  assign seg_last_s  = (BPR == 1) ? 1'b1 : seg_r;
  assign line_last_s = (line_r == 7'(LINES - 1));
  // busy_r is high exactly in LOAD, so it doubles as the ready flag.
  assign beat_s      = in_valid_i & busy_r;
  assign rd_go_s     = rd_en_i & ~busy_r;
  assign waddr_s     = line_addr(line_r, seg_r);

  // Load FSM with its counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      line_r  <= 7'd0;
      seg_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_r <= ST_LOAD;
            line_r  <= 7'd0;
            seg_r   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (beat_s) begin
            if (seg_last_s && line_last_s) begin
              state_r <= ST_DONE;
              line_r  <= 7'd0;
              seg_r   <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else if (seg_last_s) begin
              seg_r  <= 1'b0;
              line_r <= line_r + 7'd1;
            end else begin
              seg_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          line_r  <= 7'd0;
          seg_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Split the incoming beat into its four 8-pixel groups.
  for (genvar g = 0; g < 4; g++) begin : g_grp
    assign in_grp_s[g] = `CUR_LCU_GRP(in_data_i, g, PIXEL_WIDTH);
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    localparam logic [1:0] BIDX = 2'(b);
    logic [1:0]    wgrp_s;
    logic [6:0]    rline_s;
    logic [AW-1:0] addr_s;

    // Rotation: this bank takes the group that maps onto it for this line.
    assign wgrp_s = cur_grp_of_bank(BIDX, line_r[1:0]);

    // Line this bank serves: the addressed line for rows, or the line of the
    // 4-line block whose rotation puts the requested group in this bank.
    always_comb begin
      if (rd_col_i) begin
        rline_s = {rd_line_i[6:2], BIDX - rd_grp_i};
      end else begin
        rline_s = rd_line_i;
      end
    end

    // Single port: the load owns the address while it writes.
    always_comb begin
      if (beat_s) begin
        addr_s = waddr_s;
      end else begin
        addr_s = line_addr(rline_s, rd_seg_i);
      end
    end

    cur_lcu_bank #(
      .WIDTH (GW),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (beat_s),
      .re    (rd_go_s),
      .addr  (addr_s),
      .wdata (in_grp_s[wgrp_s]),
      .rdata (bank_q_s[b])
    );
  end

  // Read valid and unrotation select, captured with the bank addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      sel_r      <= 2'd0;
    end else begin
      rd_valid_r <= rd_go_s;
      if (rd_go_s) begin
        sel_r <= rd_col_i ? rd_grp_i : rd_line_i[1:0];
      end
    end
  end

  // Output slot k comes from bank (k + sel) mod 4 for both read kinds; the
  // inputs are all registers, so rd_data_o holds between reads.
  for (genvar k = 0; k < 4; k++) begin : g_out
    assign rd_data_o[DW-1-k*GW -: GW] = bank_q_s[cur_bank_idx(2'(k), sel_r)];
  end

  assign done_o     = done_r;
  assign busy_o     = busy_r;
  assign in_ready_o = busy_r;
  assign rd_valid_o = rd_valid_r;

endmodule

// File: tb/tb_cur_lcu_loader.sv
// Bench for cur_lcu_loader: one LCU-32 and one LCU-64 instance, random and
// ramp loads checked against a line/segment array model of the LCU.

module tb_cur_lcu_loader;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start32, start64;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          rd_en, rd_col, rd_seg;
  logic [6:0]    rd_line;
  logic [1:0]    rd_grp;

  logic          done32, busy32, ready32, rvalid32;
  logic          done64, busy64, ready64, rvalid64;
  logic [DW-1:0] rdata32, rdata64;

  bit            use64;
  logic          cur_done, cur_busy, cur_ready, cur_rvalid;
  logic [DW-1:0] cur_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Model: one 32-pixel word per (line, segment), index line*BPR+seg.
  logic [DW-1:0] mdl [2][192];

  always #5 clk = ~clk;

  assign cur_done   = use64 ? done64   : done32;
  assign cur_busy   = use64 ? busy64   : busy32;
  assign cur_ready  = use64 ? ready64  : ready32;
  assign cur_rvalid = use64 ? rvalid64 : rvalid32;
  assign cur_rdata  = use64 ? rdata64  : rdata32;

  cur_lcu_loader #(.PIXEL_WIDTH(8), .LCU_SIZE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(start32), .done_o(done32), .busy_o(busy32),
    .in_valid_i(in_valid), .in_ready_o(ready32), .in_data_i(in_data),
    .rd_en_i(rd_en), .rd_col_i(rd_col), .rd_line_i(rd_line), .rd_seg_i(rd_seg),
    .rd_grp_i(rd_grp), .rd_data_o(rdata32), .rd_valid_o(rvalid32)
  );

  cur_lcu_loader #(.PIXEL_WIDTH(8), .LCU_SIZE(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start_i(start64), .done_o(done64), .busy_o(busy64),
    .in_valid_i(in_valid), .in_ready_o(ready64), .in_data_i(in_data),
    .rd_en_i(rd_en), .rd_col_i(rd_col), .rd_line_i(rd_line), .rd_seg_i(rd_seg),
    .rd_grp_i(rd_grp), .rd_data_o(rdata64), .rd_valid_o(rvalid64)
  );

  function automatic logic [DW-1:0] ramp_beat(input int lcu, input int line, input int seg);
    logic [DW-1:0] d;
    for (int p = 0; p < 32; p++) d[DW-1-8*p -: 8] = 8'((line * lcu + seg * 32 + p) & 255);
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Expected read result straight from the row/column definitions.
  function automatic logic [DW-1:0] model_read(input bit w, input bit col, input int line,
                                               input int seg, input int grp);
    int bpr, base;
    logic [DW-1:0] r, src;
    bpr = w ? 2 : 1;
    if (!col) return mdl[w][line * bpr + seg];
    base = line - (line % 4);
    for (int k = 0; k < 4; k++) begin
      src = mdl[w][(base + k) * bpr + seg];
      r[DW-1-64*k -: 64] = src[DW-1-64*grp -: 64];
    end
    return r;
  endfunction

  // Drive one read and return what appears one cycle later.
  task automatic issue_read(input bit col, input int line, input int seg, input int grp,
                            output logic v, output logic [DW-1:0] d);
    rd_en = 1'b1; rd_col = col; rd_line = 7'(line); rd_seg = 1'(seg); rd_grp = 2'(grp);
    @(posedge clk); #1;
    v = cur_rvalid;
    d = cur_rdata;
  endtask

  // Run one load and report what was observed; stops early at abort_at beats.
  task automatic do_load(input bit w, input bit ramp, input bit toggle, input bit start_mid,
                         input bit read_mid, input bit b2b, input int abort_at,
                         output int iters, output int beats, output int dones,
                         output bit start_ok, output bit done_on_last, output int leaks,
                         output logic post_busy, output logic post_done);
    int total, bpr, lcu, cyc;
    bit acc, fin;
    logic [DW-1:0] d, prev_rd;
    total = w ? 192 : 48; bpr = w ? 2 : 1; lcu = w ? 64 : 32;
    cyc = 0; beats = 0; dones = 0; leaks = 0; fin = 1'b0; done_on_last = 1'b0;
    post_busy = 1'bx; post_done = 1'bx;
    use64 = w; rd_en = 1'b0; in_valid = 1'b0;
    if (w) start64 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; start64 = 1'b0;
    start_ok = (cur_busy === 1'b1) && (cur_ready === 1'b1);
    prev_rd = cur_rdata;
    while (!fin && cyc < 1000) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      d = ramp ? ramp_beat(lcu, beats / bpr, beats % bpr) : rand_beat();
      in_data = d;
      if (start_mid && cyc == 7) begin
        if (w) start64 = 1'b1; else start32 = 1'b1;
      end
      if (read_mid) begin
        rd_en = 1'b1; rd_col = 1'($urandom); rd_line = 7'($urandom_range(0, w ? 95 : 47));
        rd_seg = w ? 1'($urandom) : 1'b0; rd_grp = 2'($urandom);
      end
      acc = in_valid && (cur_ready === 1'b1);
      @(posedge clk); #1;
      start32 = 1'b0; start64 = 1'b0;
      cyc++;
      if (acc) begin
        mdl[w][beats] = d;
        beats++;
      end
      if (read_mid && ((cur_rvalid !== 1'b0) || (cur_rdata !== prev_rd))) leaks++;
      if (abort_at >= 0 && beats == abort_at) begin
        fin = 1'b1;
      end else if (cur_done === 1'b1) begin
        dones++;
        done_on_last = acc && (beats == total);
        fin = 1'b1;
      end
    end
    in_valid = 1'b0; rd_en = 1'b0;
    iters = cyc;
    if (abort_at < 0 && dones > 0) begin
      if (b2b) begin
        if (w) start64 = 1'b1; else start32 = 1'b1;
      end
      @(posedge clk); #1;
      start32 = 1'b0; start64 = 1'b0;
      post_busy = cur_busy;
      post_done = cur_done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start32 = 1'b0; start64 = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_en = 1'b0; rd_col = 1'b0; rd_line = 7'd0; rd_seg = 1'b0; rd_grp = 2'd0; use64 = 1'b0;
    #2;
    n_cmp++;
    if ({done32, busy32, ready32, rvalid32} !== 4'b0000 || rdata32 !== '0) begin
      n_err++; $display("FAIL reset32: flags=%b data=%h required flags=0000 data=0",
                        {done32, busy32, ready32, rvalid32}, rdata32);
    end
    n_cmp++;
    if ({done64, busy64, ready64, rvalid64} !== 4'b0000 || rdata64 !== '0) begin
      n_err++; $display("FAIL reset64: flags=%b data=%h required flags=0000 data=0",
                        {done64, busy64, ready64, rvalid64}, rdata64);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_valid();
    in_valid = 1'b1; in_data = rand_beat();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ready32 !== 1'b0 || ready64 !== 1'b0 || busy32 !== 1'b0) begin
        n_err++; $display("FAIL idle_ready: ready32=%b ready64=%b busy32=%b required 0 0 0",
                          ready32, ready64, busy32);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ramp_rows();
    int it, bt, dn, lk; bit sok, dl; logic pb, pd, v; logic [DW-1:0] d, e;
    do_load(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, it, bt, dn, sok, dl, lk, pb, pd);
    n_cmp++;
    if (!sok) begin n_err++; $display("FAIL ramp_start: busy/ready not high after start"); end
    n_cmp++;
    if (it !== 48 || bt !== 48 || dn !== 1) begin
      n_err++; $display("FAIL ramp_len: cycles=%0d beats=%0d dones=%0d required 48 48 1", it, bt, dn);
    end
    n_cmp++;
    if (!dl) begin n_err++; $display("FAIL ramp_done_timing: done not in cycle after beat 47"); end
    n_cmp++;
    if (pd !== 1'b0 || pb !== 1'b0) begin
      n_err++; $display("FAIL ramp_done_pulse: done=%b busy=%b after pulse required 0 0", pd, pb);
    end
    for (int p = 0; p < 32; p++) e[DW-1-8*p -: 8] = 8'(8'hA0 + p);
    issue_read(1'b0, 5, 0, 0, v, d);
    rd_en = 1'b0;
    n_cmp++;
    if (v !== 1'b1 || d !== e) begin
      n_err++; $display("FAIL ramp_row5: valid=%b data=%h required 1 %h", v, d, e);
    end
  endtask

  task automatic test_column();
    logic v; logic [DW-1:0] d, e;
    use64 = 1'b0;
    e = model_read(1'b0, 1'b1, 6, 0, 2);
    issue_read(1'b1, 6, 0, 2, v, d);
    rd_en = 1'b0;
    n_cmp++;
    if (v !== 1'b1 || d !== e) begin
      n_err++; $display("FAIL col_read: valid=%b data=%h required 1 %h", v, d, e);
    end
    n_cmp++;
    if ({d[255 -: 8], d[191 -: 8], d[127 -: 8], d[63 -: 8]} !== 32'h90B0D0F0) begin
      n_err++; $display("FAIL col_first_pix: got %h required 90b0d0f0",
                        {d[255 -: 8], d[191 -: 8], d[127 -: 8], d[63 -: 8]});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cur_rvalid !== 1'b0 || cur_rdata !== d) begin
      n_err++; $display("FAIL col_hold: valid=%b data=%h required 0 %h", cur_rvalid, cur_rdata, d);
    end
  endtask

  task automatic test_random_reads(input bit w, input int n);
    logic v; logic [DW-1:0] d, e;
    int col, line, seg, grp;
    use64 = w;
    for (int i = 0; i < n; i++) begin
      col = $urandom_range(0, 1); line = $urandom_range(0, w ? 95 : 47);
      seg = w ? $urandom_range(0, 1) : 0; grp = $urandom_range(0, 3);
      e = model_read(w, col[0], line, seg, grp);
      issue_read(col[0], line, seg, grp, v, d);
      n_cmp++;
      if (v !== 1'b1 || d !== e) begin
        n_err++; $display("FAIL rand_read lcu%0d col=%0d line=%0d seg=%0d grp=%0d: valid=%b data=%h required 1 %h",
                          w ? 64 : 32, col, line, seg, grp, v, d, e);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_busy_ignores();
    int it, bt, dn, lk; bit sok, dl; logic pb, pd;
    do_load(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, it, bt, dn, sok, dl, lk, pb, pd);
    n_cmp++;
    if (it !== 48 || bt !== 48 || dn !== 1) begin
      n_err++; $display("FAIL busy_len: cycles=%0d beats=%0d dones=%0d required 48 48 1", it, bt, dn);
    end
    n_cmp++;
    if (lk !== 0) begin n_err++; $display("FAIL busy_read: %0d cycles with read activity, required 0", lk); end
    test_random_reads(1'b0, 24);
  endtask

  task automatic test_back_to_back();
    int it, bt, dn, lk; bit sok, dl; logic pb, pd;
    do_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, it, bt, dn, sok, dl, lk, pb, pd);
    n_cmp++;
    if (pb !== 1'b0 || dn !== 1) begin
      n_err++; $display("FAIL b2b_start_in_done: busy=%b dones=%0d required 0 1", pb, dn);
    end
    do_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, it, bt, dn, sok, dl, lk, pb, pd);
    n_cmp++;
    if (!sok || it !== 48 || dn !== 1 || !dl) begin
      n_err++; $display("FAIL b2b_second: start_ok=%b cycles=%0d dones=%0d on_last=%b required 1 48 1 1",
                        sok, it, dn, dl);
    end
    test_random_reads(1'b0, 24);
  endtask

  task automatic test_lcu64_backpressure();
    int it, bt, dn, lk; bit sok, dl; logic pb, pd, v; logic [DW-1:0] d, e;
    do_load(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, it, bt, dn, sok, dl, lk, pb, pd);
    n_cmp++;
    if (bt !== 192 || dn !== 1 || it !== 383 || !dl || pd !== 1'b0) begin
      n_err++; $display("FAIL lcu64_load: beats=%0d dones=%0d cycles=%0d on_last=%b post_done=%b required 192 1 383 1 0",
                        bt, dn, it, dl, pd);
    end
    e = mdl[1][141];
    issue_read(1'b0, 70, 1, 0, v, d);
    rd_en = 1'b0;
    n_cmp++;
    if (v !== 1'b1 || d !== e) begin
      n_err++; $display("FAIL lcu64_row70s1: valid=%b data=%h required 1 %h", v, d, e);
    end
    test_random_reads(1'b1, 40);
  endtask

  task automatic test_reset_mid_load();
    int it, bt, dn, lk; bit sok, dl; logic pb, pd;
    do_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, it, bt, dn, sok, dl, lk, pb, pd);
    n_cmp++;
    if (bt !== 20 || busy32 !== 1'b1) begin
      n_err++; $display("FAIL abort_setup: beats=%0d busy=%b required 20 1", bt, busy32);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({done32, busy32, ready32, rvalid32} !== 4'b0000 || rdata32 !== '0) begin
      n_err++; $display("FAIL abort_outputs: flags=%b data=%h required flags=0000 data=0",
                        {done32, busy32, ready32, rvalid32}, rdata32);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy32, done32);
    end
    do_load(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, it, bt, dn, sok, dl, lk, pb, pd);
    n_cmp++;
    if (!sok || it !== 48 || dn !== 1 || !dl) begin
      n_err++; $display("FAIL abort_reload: start_ok=%b cycles=%0d dones=%0d on_last=%b required 1 48 1 1",
                        sok, it, dn, dl);
    end
    test_random_reads(1'b0, 24);
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_ramp_rows();
    test_column();
    test_random_reads(1'b0, 24);
    test_busy_ignores();
    test_back_to_back();
    test_lcu64_backpressure();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cur_lcu_loader.md
# cur_lcu_loader

Synthesisable current-LCU buffer for 4:2:0 video. It loads one LCU of original luma and chroma pixels from a valid/ready stream into four diagonally rotated single-port banks, then serves reads to the prediction and transform stages. A read returns either one row segment (8×4 words in the same line) or one 8×4 column block (one 8-pixel group across 4 consecutive lines) in a single cycle. It replaces the file-loaded behavioural current-MB model and is parametrised in pixel width and LCU size.

## Interface
- PIXEL_WIDTH, 8, bits per pixel
- LCU_SIZE, 32, luma LCU edge; legal values are 32 and 64 only. Derived values:
  - BPR = LCU_SIZE/32 beats per line
  - LINES = LCU_SIZE*3/2 lines
  - DEPTH = LINES*BPR words per bank
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begin loading a new LCU
- done_o  out  1  one-cycle pulse; load complete
- busy_o  out  1  high while loading
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid and ready are both high
- in_data_i  in  PIXEL_WIDTH*32  32 pixels; MSB holds the leftmost pixel
- rd_en_i  in  1  read request
- rd_col_i  in  1  0 = row-segment read, 1 = column read
- rd_line_i  in  7  line index (0..LINES-1)
- rd_seg_i  in  1  32-pixel segment within the line; must be 0 when LCU_SIZE=32
- rd_grp_i  in  2  8-pixel group; used by column reads only
- rd_data_o  out  PIXEL_WIDTH*32  read data
- rd_valid_o  out  1  read data valid

## Operation
- **Line layout:** lines 0..LCU_SIZE-1 are luma rows. Lines LCU_SIZE..LINES-1 are chroma rows. Each chroma line carries U pixels in its MSB half and V pixels in its LSB half.
- **Beat order:** one line is BPR beats, segment 0 first. Line L, segment s is stored at address A = L*BPR + s.
- **Groups:** group g (0..3) = in_data_i[PW*(32-8g)-1 : PW*(24-8g)]. Group 0 is the leftmost.
- **Rotation:** rot = L[1:0]. Group g of line L is written to bank (g+rot) mod 4 at address A. All 4 banks are written in the same cycle.
- **FSM states:**
  - IDLE: start_i → LOAD, with line and segment counters cleared.
  - LOAD: each accepted beat advances the segment counter, then the line counter. Acceptance of the beat with L=LINES-1 and s=BPR-1 → DONE.
  - DONE: one cycle, then → IDLE.
- **Load-phase rules:**
  - in_ready_o = (state==LOAD).
  - Beats presented outside LOAD are not accepted.
  - start_i is ignored in LOAD and in DONE.
- **Row read (rd_col_i=0):**
  - Every bank reads address A = rd_line_i*BPR + rd_seg_i.
  - Output group g = bank (g + rd_line_i[1:0]) mod 4. The output is the line segment exactly as it was written.
- **Column read (rd_col_i=1):**
  - base = {rd_line_i[6:2], 2'b00}; rd_line_i[1:0] is ignored.
  - Bank b reads address (base + ((b - rd_grp_i) mod 4))*BPR + rd_seg_i.
  - Output word k (k=0 in the MSB position) = group rd_grp_i of line base+k, taken from bank (rd_grp_i+k) mod 4.
- **Read/write conflict:** rd_en_i is ignored while busy_o=1. No read is issued, rd_valid_o stays 0, and rd_data_o holds its value.
- **Out-of-range reads:** rd_line_i ≥ LINES gives undefined rd_data_o. rd_valid_o still pulses.

## Timing
- **Reset values:** done_o=0, busy_o=0, in_ready_o=0, rd_valid_o=0, rd_data_o=0. State = IDLE and counters = 0.
- **Reset mid-load:** the load is aborted and the block returns to IDLE. Bank contents are undefined. No done_o is produced.
- **Load timing:**
  - busy_o and in_ready_o rise the cycle after start_i.
  - With in_valid_i held high, a load takes LINES*BPR cycles: 48 for LCU 32, 192 for LCU 64.
  - done_o pulses the cycle after the last beat is accepted. busy_o falls in that same cycle.
- **Back-to-back loads:** start_i asserted in the cycle done_o is high is ignored. The earliest new start is the cycle after done_o.
- **Reads:** latency is 1 cycle. rd_valid_o is registered rd_en_i & ~busy_o. One read per cycle with full throughput.
- **Bank RAMs:** synchronous read. The output mux select is registered alongside the address.

## Structure
- **Package cur_lcu_pkg holds:**
  - state encoding (IDLE/LOAD/DONE)
  - BPR/LINES/DEPTH derivation functions
  - bank-index function (g+rot)&3
  - group slice macros
- **Sub-module cur_lcu_bank:** single-port RAM wrapper, width PIXEL_WIDTH*8, depth DEPTH, write priority. Four instances.
- **Top level holds:** FSM, counters, write rotation, column address generation, and the registered output unrotation mux.

## Test plan
- **Ramp load, row reads:** LCU 32, PW 8. Load 48 beats where pixel p of line L = (L*32+p)&0xFF. done_o pulses 1 cycle after beat 47. A row read of line 5 returns 0xA0..0xBF.
- **Column read:** with the same data, rd_col_i=1, rd_line_i=6 (base becomes 4), rd_grp_i=2. Words k=0..3 = pixels 16..23 of lines 4,5,6,7 (first pixels 0x90, 0xB0, 0xD0, 0xF0).
- **LCU 64 with backpressure:** LCU 64. Toggle in_valid_i every cycle. Exactly 192 beats are accepted and done_o pulses once. Line 70 (chroma), seg 1, row read returns the second segment intact.
- **Busy and ignored inputs:** rd_en_i during LOAD → rd_valid_o=0 and rd_data_o unchanged. start_i during LOAD → load length unchanged. in_valid_i while IDLE → in_ready_o=0.
- **Reset mid-load:** assert rst_n=0 after 20 beats. All outputs go to 0 immediately. A subsequent full load completes normally with correct readback.
